// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared frame layout, data width and FSM encoding for the MCP3002 SPI reader.
package adc_spi_pkg;

    localparam int FRAME_BITS     = 16;
    localparam int START_IDX      = 1;
    localparam int SGL_IDX        = 2;
    localparam int CH_IDX         = 3;
    localparam int MSBF_IDX       = 4;
    localparam int NULL_IDX       = 5;
    localparam int FIRST_DATA_IDX = 6;
    localparam int DATA_W         = 10;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    // MOSI word indexed by SCK period: bit k is presented for rising edge k.
    function automatic logic [FRAME_BITS-1:0] cmd_frame(input logic ch);
        logic [FRAME_BITS-1:0] f;
        f           = '0;
        f[START_IDX] = 1'b1;
        f[SGL_IDX]   = 1'b1;
        f[CH_IDX]    = ch;
        f[MSBF_IDX]  = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// adc_sample_timer: free-running conversion-rate timer, one registered tick every SAMPLE_PERIOD cycles while enabled.
module adc_sample_timer #(
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, wrap;

    assign wrap  = cnt_q == CW'(SAMPLE_PERIOD - 1);
    assign cnt_d = (!enable || wrap) ? '0 : cnt_q + CW'(1);
    assign tick  = tick_q;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= enable && wrap;
        end
    end

endmodule

// File: rtl/spi_adc_reader.sv
// spi_adc_reader: periodic SPI mode-0 master for an MCP3002-style 10-bit ADC,
// presenting each completed sample on data_out with a data_valid level.
module spi_adc_reader
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5000,
    parameter int CHANNEL       = 0
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              adc_miso,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic              adc_mosi,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);

    localparam int                    DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]            BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]            DATA_LO  = 4'(FIRST_DATA_IDX);
    localparam logic [FRAME_BITS-1:0] CMD      = cmd_frame(1'(CHANNEL));

    if (CLK_DIV < 1 || SAMPLE_PERIOD <= 33 * CLK_DIV + 2 || CHANNEL < 0 || CHANNEL > 1) begin : g_param_check
        $error("spi_adc_reader: invalid CLK_DIV/SAMPLE_PERIOD/CHANNEL");
    end

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sr_q, sr_d, dout_q, dout_d;
    logic              cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
    logic              dv_q, dv_d, busy_q, busy_d;
    logic              tick, last;

    adc_sample_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    assign last = div_q == DIV_LAST;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = (state_q inside {SETUP, SHIFT, HOLD} && !last) ? div_q + DIV_W'(1) : '0;
        bit_d   = bit_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        dv_d    = dv_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (tick && enable) begin
                state_d = SETUP;
                bit_d   = '0;
                cs_n_d  = 1'b0;
                dv_d    = 1'b0;
                busy_d  = 1'b1;
                mosi_d  = CMD[0];
            end
            SETUP: if (last) begin
                state_d = SHIFT;
                sck_d   = 1'b1;
            end
            SHIFT: if (last) begin
                sck_d = !sck_q;
                // End of the high half: capture MISO, then the falling edge advances MOSI.
                if (sck_q) begin
                    if (bit_q >= DATA_LO)
                        sr_d = {sr_q[DATA_W-2:0], adc_miso};
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        mosi_d = CMD[bit_q + 4'd1];
                    end
                end
            end
            HOLD: if (last) begin
                state_d = DONE;
                cs_n_d  = 1'b1;
                dout_d  = sr_q;
                dv_d    = 1'b1;
                busy_d  = 1'b0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign adc_cs_n   = cs_n_q;
    assign adc_sck    = sck_q;
    assign adc_mosi   = mosi_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// tb_spi_adc_reader: directed plus randomized frames against an ADC slave model and a timing/frame reference.
module tb_spi_adc_reader;

    localparam int CD        = 2;
    localparam int SP        = 100;
    localparam int FRAME_CYC = 33 * CD;

    logic       sysclk = 0, rst_n = 1, enable = 0, adc_miso = 0;
    logic       cs0, sck0, mosi0, dv0, busy0;
    logic       cs1, sck1, mosi1, dv1, busy1;
    logic [9:0] dout0, dout1;

    int         vectors = 0, miscompares = 0;
    logic [9:0] slv_data = 0, last_exp = 0;
    logic       slv_null = 0;
    int         nrise = 0, sck_bad = 0, dv_rises = 0, cs_falls = 0, n;
    time        rt [16];
    logic [15:0] mb0 = 0, mb1 = 0;

    always #5 sysclk = ~sysclk;

    spi_adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(0)) dut0 (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .adc_miso(adc_miso),
        .adc_cs_n(cs0), .adc_sck(sck0), .adc_mosi(mosi0),
        .data_out(dout0), .data_valid(dv0), .busy(busy0)
    );

    spi_adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CHANNEL(1)) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .adc_miso(adc_miso),
        .adc_cs_n(cs1), .adc_sck(sck1), .adc_mosi(mosi1),
        .data_out(dout1), .data_valid(dv1), .busy(busy1)
    );

    function automatic logic slave_bit(input int b);
        return (b == 5) ? slv_null : (b >= 6 && b <= 15) ? slv_data[15 - b] : 1'b0;
    endfunction

    function automatic logic [15:0] exp_frame(input logic ch);
        logic [15:0] f = '0;
        f[1] = 1'b1;
        f[2] = 1'b1;
        f[3] = ch;
        f[4] = 1'b1;
        return f;
    endfunction

    always @(posedge sck0 or negedge cs0) begin
        if (sck0) begin
            if (cs0) sck_bad++;
            if (nrise < 16) begin
                rt[nrise]  = $time;
                mb0[nrise] = mosi0;
                mb1[nrise] = mosi1;
            end
            nrise++;
        end else
            nrise = 0;
    end

    // The ADC shifts its next bit out on each SCK fall.
    always @(negedge sck0 or negedge cs0) adc_miso = slave_bit(nrise);

    always @(posedge dv0) dv_rises++;
    always @(negedge cs0) cs_falls++;

    task automatic step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(output int cnt);
        cnt = 0;
        while (cs0 !== 1'b0 && cnt < SP + 50) begin
            step();
            cnt++;
        end
        check("cs_fall_seen", 32'(cs0), 0);
    endtask

    task automatic finish_frame(input logic [9:0] exp, input logic [9:0] prev, input int drop_at, input string tag);
        int  k = 0, bad = 0, tbad = 0, d0 = dv_rises;
        time tc = $time;
        while (dv0 !== 1'b1 && k < 200) begin
            if (cs0 !== 1'b0 || dout0 !== prev || busy0 !== 1'b1 || dv0 !== 1'b0) bad++;
            if ({cs1, sck1, dv1, busy1} !== {cs0, sck0, dv0, busy0}) bad++;
            if (k == drop_at) enable = 0;
            step();
            k++;
        end
        for (int i = 0; i < 16; i++)
            if (rt[i] != tc - 5 + 10 * (CD + 2 * CD * i)) tbad++;
        check({tag, "_len"}, k, FRAME_CYC);
        check({tag, "_data"}, 32'(dout0), 32'(exp));
        check({tag, "_data_ch1"}, 32'(dout1), 32'(exp));
        check({tag, "_valid"}, 32'(dv0), 1);
        check({tag, "_busy"}, 32'(busy0), 0);
        check({tag, "_cs_hi"}, 32'(cs0), 1);
        check({tag, "_in_frame"}, bad, 0);
        check({tag, "_rises"}, nrise, 16);
        check({tag, "_dv_rises"}, dv_rises - d0, 1);
        check({tag, "_mosi_ch0"}, 32'(mb0), 32'(exp_frame(1'b0)));
        check({tag, "_mosi_ch1"}, 32'(mb1), 32'(exp_frame(1'b1)));
        check({tag, "_sck_time"}, tbad, 0);
        check({tag, "_sck_idle"}, sck_bad, 0);
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (3) step();
        check("rst_cs_n", 32'(cs0), 1);
        check("rst_sck", 32'(sck0), 0);
        check("rst_mosi", 32'(mosi0), 0);
        check("rst_dout", 32'(dout0), 0);
        check("rst_valid", 32'(dv0), 0);
        check("rst_busy", 32'(busy0), 0);
        rst_n = 1;
        repeat (3) step();
        check("idle_disabled", 32'(cs0), 1);

        slv_data = 10'h2A5;
        enable   = 1;
        wait_cs(n);
        check("first_cs_delay", n, SP + 1);
        finish_frame(10'h2A5, 10'h000, -1, "t1");

        slv_data = 10'h000;
        wait_cs(n);
        finish_frame(10'h000, 10'h2A5, -1, "b2b0");
        slv_data = 10'h3FF;
        wait_cs(n);
        finish_frame(10'h3FF, 10'h000, -1, "b2b1");

        slv_null = 1;
        slv_data = 10'h155;
        wait_cs(n);
        finish_frame(10'h155, 10'h3FF, -1, "null");
        last_exp = 10'h155;

        for (int i = 0; i < 4; i++) begin
            slv_data = 10'($urandom);
            slv_null = 1'($urandom);
            wait_cs(n);
            finish_frame(slv_data, last_exp, -1, "rand");
            last_exp = slv_data;
        end

        slv_null = 0;
        slv_data = 10'h1C3;
        wait_cs(n);
        finish_frame(10'h1C3, last_exp, 19, "drop_en");
        n = cs_falls;
        repeat (500) step();
        check("no_restart", cs_falls - n, 0);
        check("no_restart_cs", 32'(cs0), 1);

        enable = 1;
        wait_cs(n);
        check("reenable_delay", n, SP + 1);
        repeat (29) step();
        #1 rst_n = 0;
        #1;
        check("async_cs_n", 32'(cs0), 1);
        check("async_sck", 32'(sck0), 0);
        check("async_dout", 32'(dout0), 0);
        check("async_valid", 32'(dv0), 0);
        check("async_busy", 32'(busy0), 0);
        @(negedge sysclk);
        rst_n    = 1;
        slv_data = 10'h0F0;
        wait_cs(n);
        check("post_rst_delay", n, SP + 1);
        finish_frame(10'h0F0, 10'h000, -1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
